// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised storage behind a request/response
// port with a fixed wait-state latency, byte-masked writes and error replies.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    // Counter start value; unused when LATENCY==1 (IDLE goes straight to RESP).
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;

    // Request captured at acceptance; later input changes are ignored.
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  rd_q, wr_q, err_q;

    // Request currently being worked on: live inputs on the accepting edge,
    // latched copy afterwards (only matters when LATENCY==1).
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic                  cur_rd, cur_wr, cur_err;
    logic                  req_err;
    logic                  enter_resp;
    logic                  mem_we;

    logic [31:0]           mem [DEPTH];

    // Address bits [1:0] select a byte within the word and play no part here.
    logic                  unused_byte_offset;
    assign unused_byte_offset = ^mem_address[1:0];

    // Error: address beyond storage, or conflicting read+write strobes.
    assign req_err = (|mem_address[31:ADDR_WIDTH+2]) | (mem_read & mem_write);

    // Next-state, counter and response outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        mem_resp  = 1'b0;
        mem_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Strobes still high here belong to the completing request.
                mem_resp  = 1'b1;
                mem_error = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select live or latched request fields and detect the edge into RESP.
    always_comb begin
        cur_idx    = accept ? mem_address[ADDR_WIDTH+1:2] : idx_q;
        cur_wdata  = accept ? mem_wdata : wdata_q;
        cur_be     = accept ? mem_byte_enable : be_q;
        cur_rd     = accept ? mem_read : rd_q;
        cur_wr     = accept ? mem_write : wr_q;
        cur_err    = accept ? req_err : err_q;
        enter_resp = (state_d == RESP) && (state_q != RESP);
        // A reset arriving on the completing edge cancels the pending write.
        mem_we     = enter_resp & cur_wr & ~cur_err & ~rst;
    end

    // Control state, latched request and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= mem_address[ADDR_WIDTH+1:2];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                err_q   <= req_err;
            end
            if (enter_resp) begin
                if (cur_err) begin
                    mem_rdata <= 32'd0;
                end else if (cur_rd) begin
                    mem_rdata <= mem[cur_idx];
                end
            end
        end
    end

    // Byte-masked storage write on the edge entering RESP.
    // NOTE: the storage array has no reset; its contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: a LATENCY=3 instance for the main tests and
// a LATENCY=1 instance for the single-cycle build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp, mem_error;
    logic [31:0] mem_rdata;

    logic        b_mem_read, b_mem_write;
    logic [31:0] b_mem_address, b_mem_wdata;
    logic [3:0]  b_mem_byte_enable;
    logic        b_mem_resp, b_mem_error;
    logic [31:0] b_mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_byte_enable(b_mem_byte_enable),
        .mem_resp(b_mem_resp), .mem_rdata(b_mem_rdata), .mem_error(b_mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        if (!sel) begin
            mem_read = rd; mem_write = wr; mem_address = addr;
            mem_wdata = wdata; mem_byte_enable = be;
        end else begin
            b_mem_read = rd; b_mem_write = wr; b_mem_address = addr;
            b_mem_wdata = wdata; b_mem_byte_enable = be;
        end
    endtask

    // One request: drive on a falling edge, then check mem_resp/mem_error on
    // each following falling edge up to the expected response cycle.
    task automatic transact(input bit sel, input int lat, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit exp_err,
                            input bit chk_data, input logic [31:0] exp_data,
                            input bit hold, input string tag);
        @(negedge clk);
        drive(sel, rd, wr, addr, wdata, be);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_resp"}, 32'(sel ? b_mem_resp : mem_resp), 32'(k == lat));
            check({tag, "_err"}, 32'(sel ? b_mem_error : mem_error), 32'((k == lat) && exp_err));
        end
        if (chk_data) check({tag, "_rdata"}, sel ? b_mem_rdata : mem_rdata, exp_data);
        if (!hold) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("rst_resp", 32'(mem_resp), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_err", 32'(mem_error), 32'd0);
        check("rst_b_resp", 32'(b_mem_resp), 32'd0);
        rst = 1'b0;

        // Full write then read back; resp in cycle 3 of each.
        transact(0, 3, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'd0, 0, "t1_wr");
        transact(0, 3, 1, 0, 32'h10, 32'd0, 4'h0, 0, 1, 32'hDEADBEEF, 0, "t1_rd");

        // Partial write; rdata must not change on a write response.
        transact(0, 3, 0, 1, 32'h10, 32'h11223344, 4'b0101, 0, 1, 32'hDEADBEEF, 0, "t2_wr");
        transact(0, 3, 1, 0, 32'h10, 32'd0, 4'h0, 0, 1, 32'hDE22BE44, 0, "t2_rd");
        // Empty mask completes but leaves the word alone.
        transact(0, 3, 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, 32'd0, 0, "t2_be0");
        transact(0, 3, 1, 0, 32'h10, 32'd0, 4'h0, 0, 1, 32'hDE22BE44, 0, "t2_rd0");

        // Errors: out-of-range address and read+write together.
        transact(0, 3, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 32'd0, 0, "t3_wr");
        transact(0, 3, 1, 0, 32'h1000, 32'd0, 4'h0, 1, 1, 32'd0, 0, "t3_oor");
        transact(0, 3, 1, 0, 32'h10, 32'd0, 4'h0, 0, 1, 32'hDE22BE44, 0, "t3_rd10");
        transact(0, 3, 1, 1, 32'h20, 32'h12345678, 4'hF, 1, 1, 32'd0, 0, "t3_rw");
        transact(0, 3, 1, 0, 32'h20, 32'd0, 4'h0, 0, 1, 32'hCAFEF00D, 0, "t3_rd20");

        // Back-to-back reads with the strobe held through the RESP cycle.
        transact(0, 3, 1, 0, 32'h10, 32'd0, 4'h0, 0, 1, 32'hDE22BE44, 1, "t4_a");
        @(negedge clk);
        check("t4_nodup", 32'(mem_resp), 32'd0);
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t4_b_resp", 32'(mem_resp), 32'(k == 3));
        end
        check("t4_b_rdata", mem_rdata, 32'hCAFEF00D);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_quiet", 32'(mem_resp), 32'd0);
        end

        // Reset in the middle of a write.
        transact(0, 3, 0, 1, 32'h40, 32'h00000000, 4'hF, 0, 1, 32'hCAFEF00D, 0, "t5_clr");
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_resp", 32'(mem_resp), 32'd0);
        check("t5_rst_rdata", mem_rdata, 32'd0);
        check("t5_rst_err", 32'(mem_error), 32'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_noresp", 32'(mem_resp), 32'd0);
        end
        transact(0, 3, 1, 0, 32'h40, 32'd0, 4'h0, 0, 1, 32'h00000000, 0, "t5_rd");

        // Single-cycle build; low address bits ignored.
        transact(1, 1, 0, 1, 32'h8, 32'hA5A55A5A, 4'hF, 0, 0, 32'd0, 0, "t6_wr8");
        transact(1, 1, 0, 1, 32'hC, 32'h0BADC0DE, 4'hF, 0, 0, 32'd0, 0, "t6_wrc");
        transact(1, 1, 1, 0, 32'hB, 32'd0, 4'h0, 0, 1, 32'hA5A55A5A, 0, "t6_rd");
        transact(1, 1, 1, 0, 32'hF, 32'd0, 4'h0, 0, 1, 32'h0BADC0DE, 0, "t6_rdc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port. It services the requests that the load/store datapath issues using a word address, write data and an rv32i_mem_wmask byte mask.
- Word-organised synchronous storage with a fixed, parameterised wait-state latency and byte-masked writes.
- Each accepted request gets exactly one mem_resp pulse.
- Used as the data-memory slave in CPU-level simulation and as the backing store behind cache bring-up.

Parameters:
ADDR_WIDTH, 10, word-index bits; storage holds 2**ADDR_WIDTH 32-bit words.
LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous active-high reset.
mem_read  input  1  read request; held by initiator until mem_resp.
mem_write  input  1  write request; held by initiator until mem_resp.
mem_address  input  32  byte address (rv32i_word); bits [1:0] ignored.
mem_wdata  input  32  write data (rv32i_word).
mem_byte_enable  input  4  write byte mask (rv32i_mem_wmask); bit i enables byte i (bits 8i+7:8i).
mem_resp  output  1  one-cycle completion pulse.
mem_rdata  output  32  read data; valid in the mem_resp cycle of a read.
mem_error  output  1  high only together with mem_resp for an errored request.

Behaviour:
- Reset (async assert): mem_resp=0, mem_rdata=0, mem_error=0, FSM=IDLE, latency counter=0, latched request cleared. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high at an edge, latch address, wdata, byte_enable, read and write flags, and the error condition. That edge is acceptance.
  - Next state is RESP if LATENCY==1. Otherwise it is WAIT with counter=LATENCY-2.
- WAIT: counter decrements each edge; at counter==0 go to RESP.
- RESP: mem_resp=1 for exactly this one cycle, then IDLE.
  - No request is sampled in RESP; the initiator's still-high strobe in this cycle belongs to the completing request.
- Timing: request first visible in cycle 0 means mem_resp is high in cycle LATENCY. Back-to-back: a new request visible in cycle LATENCY+1 is accepted, giving a minimum issue interval of LATENCY+1 cycles.
- Inputs are latched at acceptance; changes while in WAIT or RESP are ignored.
- Word index = mem_address[ADDR_WIDTH+1:2].
- Error condition is either of:
  - any bit of mem_address[31:ADDR_WIDTH+2] set;
  - mem_read and mem_write both high at acceptance.
- Error response: mem_resp=1 and mem_error=1, mem_rdata=0, storage unchanged.
- Read: mem_rdata is driven from storage at the latched index. The value is registered so it is valid during the RESP cycle, and it holds until the next read or errored response.
- Write:
  - On the edge entering RESP, each byte i with byte_enable[i]=1 is replaced by wdata byte i; other bytes are unchanged.
  - mem_rdata is unchanged by writes.
  - byte_enable=4'b0000 still completes normally with storage unchanged.
- Read-after-write: a read accepted after a write's mem_resp returns the written data.
- Reset mid-operation (WAIT or RESP): the pending request is dropped, no mem_resp is issued, a pending write is not performed, and storage keeps its prior contents.
- mem_error is 0 in every cycle where mem_resp is 0.

Test Plan:
1. LATENCY=3. Write addr 0x0000_0010, wdata 0xDEADBEEF, be=4'b1111, then read 0x10 -> mem_resp in cycle 3 of each request; read mem_rdata=0xDEADBEEF; mem_error=0.
2. Word at 0x10 = 0xDEADBEEF. Write wdata 0x11223344 with be=4'b0101, then read -> 0xDE22BE44.
3. Read 0x0000_1000 (bit 12 set, ADDR_WIDTH=10); also a request with mem_read=mem_write=1 at 0x20 holding 0xCAFEF00D -> each gives mem_resp=1, mem_error=1, mem_rdata=0, and 0x20 still reads back 0xCAFEF00D.
4. Back-to-back reads, strobe held across the mem_resp cycle and new address in cycle 4 -> exactly one mem_resp per request, at cycles 3 and 7; no duplicate acceptance in RESP.
5. Word 0x40 = 0x0. Assert rst in cycle 1 of a write of 0xFFFFFFFF to 0x40 -> no mem_resp; all outputs 0 immediately; later read of 0x40 returns 0x00000000.
6. LATENCY=1 build. Read with mem_address[1:0]=2'b11 -> mem_resp in cycle 1; data is the aligned word.
